// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
//
// Response-path companion to the master-bus address decoder. The decoder
// supplies the slave index (chipselect) and a decode fault; this block latches
// the index when a bus cycle starts, strobes exactly one slave, and returns
// that slave's ack and read data to the master through registers. Decode
// faults and slaves that never ack (watchdog) both turn into one-cycle bus
// errors.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active high
//   cyc_i, stb_i   master bus cycle / strobe
//   chipselect     decoded slave index (0 = no slave)
//   fault_i        decode fault from the decoder
//   slave_dat_i    16 slave read-data slots, slot n at [n*DW +: DW]
//   slave_ack_i    per-slave ack
//   stb_o          one-hot strobe to the selected slave
//   dat_o          registered read data to the master
//   ack_o, err_o   one-cycle ack / bus error to the master
//   timeout_o      sticky watchdog flag, cleared by timeout_clr_i
//   timeout_clr_i  clears timeout_o (a simultaneous timeout wins)
//   timeout_cs_o   chipselect of the most recent timed-out access
// -----------------------------------------------------------------------------
module bus_responder #(
    parameter int unsigned TIMEOUT = 255,  // ACTIVE cycles before a timeout error (2..65535)
    parameter int unsigned DW      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic [3:0]       chipselect,
    input  logic             fault_i,
    input  logic [16*DW-1:0] slave_dat_i,
    input  logic [15:0]      slave_ack_i,
    output logic [15:0]      stb_o,
    output logic [DW-1:0]    dat_o,
    output logic             ack_o,
    output logic             err_o,
    output logic             timeout_o,
    input  logic             timeout_clr_i,
    output logic [3:0]       timeout_cs_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ERR    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [15:0] CNT_MAX  = 16'(TIMEOUT);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]    state_q,      state_d;
    logic [3:0]    sel_q,        sel_d;
    logic [15:0]   cnt_q,        cnt_d;
    logic [DW-1:0] dat_q,        dat_d;
    logic          ack_q,        ack_d;
    logic          err_q,        err_d;
    logic          timeout_q,    timeout_d;
    logic [3:0]    timeout_cs_q, timeout_cs_d;

    logic          timeout_set;
    logic [DW-1:0] sel_dat;

    // Read-data mux for the latched slave index.
    always_comb begin
        sel_dat = '0;
        for (int n = 0; n < 16; n++) begin
            if (sel_q == 4'(n)) begin
                sel_dat = slave_dat_i[n*DW +: DW];
            end
        end
    end

    // The strobe follows the master combinationally but only ever targets the
    // index latched at cycle start, so a decoder change mid-cycle cannot move it.
    always_comb begin
        stb_o = '0;
        if (state_q == ST_ACTIVE) begin
            stb_o[sel_q] = cyc_i & stb_i;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path through
        // the block leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        dat_d        = dat_q;
        ack_d        = 1'b0;  // ack/err are pulses: only the entry into DONE sets them
        err_d        = 1'b0;
        timeout_cs_d = timeout_cs_q;
        timeout_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    if (fault_i || (chipselect == 4'd0)) begin
                        state_d = ST_ERR;
                    end else begin
                        sel_d   = chipselect;
                        cnt_d   = '0;
                        state_d = ST_ACTIVE;
                    end
                end
            end

            ST_ACTIVE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // A dropped cycle abandons the access; the slave is no longer
                // strobed, so nothing it returns this cycle is forwarded.
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (slave_ack_i[sel_q]) begin
                    dat_d   = sel_dat;
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    dat_d        = '0;
                    err_d        = 1'b1;
                    timeout_set  = 1'b1;
                    timeout_cs_d = sel_q;
                    state_d      = ST_DONE;
                end
            end

            ST_ERR: begin
                dat_d   = '0;
                err_d   = 1'b1;
                state_d = ST_DONE;
            end

            // One mandatory bubble between accesses.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flag: a timeout in the same cycle as a clear keeps it set.
    always_comb begin
        timeout_d = timeout_q;
        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            dat_q        <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_cs_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            dat_q        <= dat_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            timeout_cs_q <= timeout_cs_d;
        end
    end

    assign dat_o        = dat_q;
    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign timeout_o    = timeout_q;
    assign timeout_cs_o = timeout_cs_q;

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Return-path companion to the address decoder on the master bus; the decoder drives the forward path (chipselect, fault), this block drives the response path.
- Latches the decoded chipselect at cycle start and forwards the strobe to exactly one slave.
- Muxes that slave's ack/data back to the master, registered.
- Issues bus errors for decode faults and for slaves that never ack (watchdog timeout).

Parameters:
- TIMEOUT, 255: cycles in ACTIVE without slave ack before a timeout error is forced (legal range 2..65535).
- DW, 32: data width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- cyc_i  in  1  master bus cycle.
- stb_i  in  1  master strobe.
- chipselect  in  4  decoded slave index from the decoder (0 = none).
- fault_i  in  1  decode fault from the decoder.
- slave_dat_i  in  16*DW  slave read data, slot n at bits [n*DW +: DW].
- slave_ack_i  in  16  per-slave ack.
- stb_o  out  16  one-hot strobe to the selected slave.
- dat_o  out  DW  registered read data to master.
- ack_o  out  1  one-cycle ack to master.
- err_o  out  1  one-cycle bus error to master.
- timeout_o  out  1  sticky flag, set on any watchdog timeout.
- timeout_clr_i  in  1  clears timeout_o.
- timeout_cs_o  out  4  chipselect of the most recent timed-out access.

Behaviour:
- Reset: state IDLE, sel=0, cnt=0, stb_o=0, dat_o=0, ack_o=0, err_o=0, timeout_o=0, timeout_cs_o=0.
- Reset asserted mid-transaction wins over all other events; outputs take reset values at the next edge.
- States: IDLE, ACTIVE, ERR, DONE.
- IDLE:
  - On cyc_i & stb_i with fault_i=1 or chipselect=0: go to ERR.
  - On cyc_i & stb_i with a valid chipselect: sel<=chipselect, cnt<=0, go to ACTIVE.
  - stb_o=0 in IDLE.
- ACTIVE:
  - stb_o[sel] = cyc_i & stb_i (combinational); all other stb_o bits are 0.
  - cnt increments each cycle, saturating at TIMEOUT.
  - On slave_ack_i[sel]: dat_o<=slave_dat_i[sel], ack_o<=1, go to DONE.
  - Else if cnt==TIMEOUT-1: err_o<=1, dat_o<=0, timeout_o<=1, timeout_cs_o<=sel, go to DONE.
  - Ack and timeout in the same cycle: the ack wins.
  - Acks on non-selected slots are ignored.
  - cyc_i deasserted: abort. Go to IDLE, no ack/err, stb_o drops the same cycle.
- ERR: err_o<=1, dat_o<=0, go to DONE.
- DONE:
  - ack_o/err_o are high for exactly this one cycle and cleared on exit.
  - stb_o=0.
  - Return to IDLE unconditionally. This gives one mandatory bubble between accesses, so no double strobe is possible.
- Latency:
  - Slave ack at edge N gives ack_o high during cycle N+1.
  - Fault start at edge N gives err_o high during cycle N+2.
- ack_o and err_o are never high together.
- dat_o holds its value after ack until the next ack or error.
- timeout_o:
  - Set on timeout, cleared by timeout_clr_i.
  - Set and clear in the same cycle: set wins.
- sel is stable for the whole cycle. A change in chipselect during ACTIVE does not move stb_o.

Test Plan:
- Read cs=7: slave 7 acks on the 3rd ACTIVE cycle with 0xDEADBEEF -> stb_o=0x0080 for 3 cycles, then ack_o=1 for 1 cycle with dat_o=0xDEADBEEF, no other slave strobed.
- fault_i=1 (or cs=0) at cycle start -> stb_o stays 0, err_o=1 exactly 2 cycles later for 1 cycle, dat_o=0.
- TIMEOUT=8, cs=9, no ack -> err_o after 8 ACTIVE cycles, timeout_o=1, timeout_cs_o=9; timeout_clr_i pulse -> timeout_o=0.
- Ack on the TIMEOUT-1 cycle -> ack_o=1, err_o=0, timeout_o stays 0; stray ack on slave 3 while sel=6 -> ignored.
- cyc_i drops in ACTIVE at cs=5 -> stb_o=0 same cycle, state IDLE next, no ack/err; a later ack from slave 5 is ignored.
- rst_i asserted during ACTIVE -> all outputs 0 next edge. Back-to-back accesses cs=2 then cs=6 -> one DONE bubble between them, stb_o switches 0x0004 -> 0 -> 0x0040.
